// File: rtl/puzzle_pkg.sv
// Shared types and constants for the 8-puzzle slide engine and search controller.
// Board cells, blank position, depth and direction history live in an 8-bit register file.
package puzzle_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [4:0] CELL_BASE  = 5'd8;
    localparam logic [4:0] POS_ADDR   = 5'd17;
    localparam logic [4:0] DEPTH_ADDR = 5'd18;
    localparam logic [4:0] HIST_BASE  = 5'd19;
    localparam int         MAX_DEPTH  = 16;

    localparam logic [3:0] BOARD_CELLS = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_RD_TILE,
        S_WR_OLD,
        S_WR_NEW,
        S_WR_POS,
        S_WR_HIST,
        S_WR_DEPTH,
        S_DONE
    } state_t;

    typedef struct packed {
        logic       we;
        logic [4:0] dst;
        logic [7:0] wdata;
    } rf_wr_t;

    // Four 2-bit moves per history byte; slot k holds the move made at depth 4n+k.
    function automatic logic [7:0] hist_insert(input logic [7:0] h, input logic [1:0] k,
                                               input logic [1:0] d);
        logic [7:0] r;
        r = h;
        r[{k, 1'b0} +: 2] = d;
        return r;
    endfunction

endpackage

// File: rtl/puzzle_slide_engine_if.sv
// Command and register-file bus of the slide engine.
// master = engine side, slave = search controller / register file side.
interface puzzle_slide_engine_if;
    logic       start;
    logic [1:0] dir;
    logic       busy;
    logic       done;
    logic       illegal;
    logic [4:0] rf_src0;
    logic [4:0] rf_src1;
    logic [7:0] rf_data0;
    logic [7:0] rf_data1;
    logic [4:0] rf_dst;
    logic       rf_we;
    logic [7:0] rf_wdata;

    modport master (
        input  start, dir, rf_data0, rf_data1,
        output busy, done, illegal, rf_src0, rf_src1, rf_dst, rf_we, rf_wdata
    );

    modport slave (
        output start, dir, rf_data0, rf_data1,
        input  busy, done, illegal, rf_src0, rf_src1, rf_dst, rf_we, rf_wdata
    );
endinterface

// File: rtl/slide_legal.sv
// Geometry check for one blank move on the 3x3 board; also used for search pruning.
module slide_legal
    import puzzle_pkg::*;
(
    input  logic [3:0] pos,
    input  logic [1:0] dir,
    output logic       legal,
    output logic [3:0] newpos
);
    logic [1:0] row;
    logic [1:0] col;

    always_comb begin
        row = 2'd0;
        col = 2'd0;
        case (pos)
            4'd0: begin row = 2'd0; col = 2'd0; end
            4'd1: begin row = 2'd0; col = 2'd1; end
            4'd2: begin row = 2'd0; col = 2'd2; end
            4'd3: begin row = 2'd1; col = 2'd0; end
            4'd4: begin row = 2'd1; col = 2'd1; end
            4'd5: begin row = 2'd1; col = 2'd2; end
            4'd6: begin row = 2'd2; col = 2'd0; end
            4'd7: begin row = 2'd2; col = 2'd1; end
            4'd8: begin row = 2'd2; col = 2'd2; end
            default: begin row = 2'd0; col = 2'd0; end
        endcase
    end

    always_comb begin
        legal  = (pos < BOARD_CELLS);
        newpos = pos;
        case (dir)
            DIR_UP:    begin legal = legal && (row != 2'd0); newpos = pos - 4'd3; end
            DIR_DOWN:  begin legal = legal && (row != 2'd2); newpos = pos + 4'd3; end
            DIR_LEFT:  begin legal = legal && (col != 2'd0); newpos = pos - 4'd1; end
            default:   begin legal = legal && (col != 2'd2); newpos = pos + 4'd1; end
        endcase
    end
endmodule

// File: rtl/puzzle_slide_engine.sv
// Executes one 8-puzzle slide per start: fetch, check, read tile/history, five byte writes.
// All outputs are registered and reflect the state currently occupied.
module puzzle_slide_engine
    import puzzle_pkg::*;
#(
    parameter logic [4:0] CELL_BASE  = puzzle_pkg::CELL_BASE,
    parameter logic [4:0] POS_ADDR   = puzzle_pkg::POS_ADDR,
    parameter logic [4:0] DEPTH_ADDR = puzzle_pkg::DEPTH_ADDR,
    parameter logic [4:0] HIST_BASE  = puzzle_pkg::HIST_BASE,
    parameter int         MAX_DEPTH  = puzzle_pkg::MAX_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    puzzle_slide_engine_if.master        bus
);
    state_t     state;
    logic [1:0] dir_q;
    logic [3:0] pos_q;
    logic [3:0] newpos_q;
    logic [7:0] depth_q;
    logic [7:0] hist_q;
    logic       busy_q;
    logic       done_q;
    logic       illegal_q;
    logic [4:0] src0_q;
    logic [4:0] src1_q;
    rf_wr_t     wr_q;

    logic       mv_legal;
    logic [3:0] mv_newpos;
    logic [4:0] hist_addr;

    slide_legal u_legal (
        .pos    (pos_q),
        .dir    (dir_q),
        .legal  (mv_legal),
        .newpos (mv_newpos)
    );

    assign hist_addr = HIST_BASE + 5'(depth_q[7:2]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dir_q     <= '0;
            pos_q     <= '0;
            newpos_q  <= '0;
            depth_q   <= '0;
            hist_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            src0_q    <= '0;
            src1_q    <= '0;
            wr_q      <= '0;
        end else begin
            // Strobes and addresses default low; each state sets what the next state shows.
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            src0_q    <= '0;
            src1_q    <= '0;
            wr_q      <= '0;
            case (state)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        dir_q  <= bus.dir;
                        busy_q <= 1'b1;
                        src0_q <= POS_ADDR;
                        src1_q <= DEPTH_ADDR;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    pos_q   <= bus.rf_data0[3:0];
                    depth_q <= bus.rf_data1;
                    state   <= S_CHECK;
                end
                S_CHECK: begin
                    if (!mv_legal || (depth_q >= 8'(MAX_DEPTH))) begin
                        done_q    <= 1'b1;
                        illegal_q <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        newpos_q <= mv_newpos;
                        src0_q   <= CELL_BASE + 5'(mv_newpos);
                        src1_q   <= hist_addr;
                        state    <= S_RD_TILE;
                    end
                end
                S_RD_TILE: begin
                    hist_q <= bus.rf_data1;
                    wr_q   <= '{we: 1'b1, dst: CELL_BASE + 5'(pos_q), wdata: bus.rf_data0};
                    state  <= S_WR_OLD;
                end
                S_WR_OLD: begin
                    wr_q  <= '{we: 1'b1, dst: CELL_BASE + 5'(newpos_q), wdata: 8'h00};
                    state <= S_WR_NEW;
                end
                S_WR_NEW: begin
                    wr_q  <= '{we: 1'b1, dst: POS_ADDR, wdata: {4'h0, newpos_q}};
                    state <= S_WR_POS;
                end
                S_WR_POS: begin
                    wr_q  <= '{we: 1'b1, dst: hist_addr,
                               wdata: hist_insert(hist_q, depth_q[1:0], dir_q)};
                    state <= S_WR_HIST;
                end
                S_WR_HIST: begin
                    wr_q  <= '{we: 1'b1, dst: DEPTH_ADDR, wdata: depth_q + 8'd1};
                    state <= S_WR_DEPTH;
                end
                S_WR_DEPTH: begin
                    done_q <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.illegal  = illegal_q;
    assign bus.rf_src0  = src0_q;
    assign bus.rf_src1  = src1_q;
    assign bus.rf_we    = wr_q.we;
    assign bus.rf_dst   = wr_q.dst;
    assign bus.rf_wdata = wr_q.wdata;
endmodule

// File: tb/tb_puzzle_slide_engine.sv
// Randomized scoreboard bench for puzzle_slide_engine with a register-file model.
module tb_puzzle_slide_engine;
    import puzzle_pkg::*;

    typedef struct { logic [4:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic ill; int lat; } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    puzzle_slide_engine_if bus();
    puzzle_slide_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] rf    [0:31];
    logic [7:0] mem_m [0:31];
    logic       tb_we = 1'b0;
    logic [4:0] tb_a  = '0;
    logic [7:0] tb_d  = '0;
    int         cyc   = 0;
    int         acc   = 0;
    int         checks = 0;
    int         errors = 0;
    wr_t        expq  [$];
    done_t      doneq [$];
    wr_t        mon_w;
    done_t      mon_d;

    assign bus.rf_data0 = rf[bus.rf_src0];
    assign bus.rf_data1 = rf[bus.rf_src1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rf_we) rf[bus.rf_dst] <= bus.rf_wdata;
        else if (tb_we) rf[tb_a] <= tb_d;
    end

    // Monitor: every write and every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rf_we) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got [%0d]<=%02h, required no write", bus.rf_dst, bus.rf_wdata);
                end else begin
                    mon_w = expq.pop_front();
                    if (bus.rf_dst !== mon_w.a || bus.rf_wdata !== mon_w.d) begin
                        errors++;
                        $display("FAIL wr: got [%0d]<=%02h, required [%0d]<=%02h", bus.rf_dst, bus.rf_wdata, mon_w.a, mon_w.d);
                    end
                end
            end
            if (bus.done) begin
                checks++;
                if (doneq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got done illegal=%0d", bus.illegal);
                end else begin
                    mon_d = doneq.pop_front();
                    if (bus.illegal !== mon_d.ill || (cyc - acc + 1) != mon_d.lat) begin
                        errors++;
                        $display("FAIL done: got illegal=%0d cycle=%0d, required illegal=%0d cycle=%0d", bus.illegal, cyc - acc + 1, mon_d.ill, mon_d.lat);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    // Copy the model's view of addresses 8..22 into the register file.
    task automatic sync_rf();
        for (int i = 8; i <= 22; i++) begin
            @(negedge clk);
            tb_we = 1'b1; tb_a = 5'(i); tb_d = mem_m[i];
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic preset(input logic [7:0] posb, input logic [7:0] depthb, input bit rnd_hist);
        int t;
        t = 1;
        for (int i = 0; i < 9; i++) begin
            if (i == int'(posb[3:0])) mem_m[8 + i] = 8'h00;
            else begin mem_m[8 + i] = 8'(t); t++; end
        end
        mem_m[17] = posb;
        mem_m[18] = depthb;
        for (int i = 19; i <= 22; i++) mem_m[i] = rnd_hist ? 8'($urandom) : 8'h00;
    endtask

    // Reference model: applies the puzzle rules to mem_m and queues what the DUT must do.
    task automatic model_cmd(input logic [1:0] d, input int keep);
        int p, dp, row, col, np;
        bit ok;
        wr_t w [5];
        logic [7:0] h;
        p   = int'(mem_m[17][3:0]);
        dp  = int'(mem_m[18]);
        row = p / 3;
        col = p % 3;
        ok  = (p <= 8) && (dp < 16);
        case (d)
            2'b00: begin ok = ok && (row != 0); np = p - 3; end
            2'b01: begin ok = ok && (row != 2); np = p + 3; end
            2'b10: begin ok = ok && (col != 0); np = p - 1; end
            default: begin ok = ok && (col != 2); np = p + 1; end
        endcase
        if (!ok) begin
            doneq.push_back('{1'b1, 3});
        end else begin
            w[0] = '{5'(8 + p), mem_m[8 + np]};
            w[1] = '{5'(8 + np), 8'h00};
            w[2] = '{5'd17, 8'(np)};
            h = mem_m[19 + dp / 4];
            h[2 * (dp % 4) +: 2] = d;
            w[3] = '{5'(19 + dp / 4), h};
            w[4] = '{5'd18, 8'(dp + 1)};
            for (int i = 0; i < keep; i++) begin
                expq.push_back(w[i]);
                mem_m[w[i].a] = w[i].d;
            end
            if (keep == 5) doneq.push_back('{1'b0, 9});
        end
    endtask

    task automatic issue(input logic [1:0] d, input bit poke);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.dir = d; acc = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0; bus.dir = 2'($urandom);
        n = 1;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
            bus.start = (poke && n == 3);
            if (poke && n == 3) bus.dir = ~d;
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
        end
    endtask

    initial begin
        logic [7:0] pb;
        logic [1:0] rd;
        bus.start = 1'b0;
        bus.dir   = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_busy",    32'(bus.busy), 0);
        chk("rst_done",    32'(bus.done), 0);
        chk("rst_illegal", 32'(bus.illegal), 0);
        chk("rst_we",      32'(bus.rf_we), 0);
        chk("rst_dst",     32'(bus.rf_dst), 0);
        chk("rst_wdata",   32'(bus.rf_wdata), 0);
        chk("rst_src0",    32'(bus.rf_src0), 0);
        chk("rst_src1",    32'(bus.rf_src1), 0);
        rst_n = 1'b1;

        // Blank at centre, tile 2 above it, slide up then right.
        preset(8'd4, 8'd0, 1'b0);
        mem_m[9] = 8'h02;
        sync_rf();
        model_cmd(2'b00, 5); issue(2'b00, 1'b0);
        chk("up_cell12", 32'(rf[12]), 32'h02);
        chk("up_pos",    32'(rf[17]), 32'h01);
        chk("up_depth",  32'(rf[18]), 32'h01);
        model_cmd(2'b11, 5); issue(2'b11, 1'b1);
        chk("right_hist",  32'(rf[19]), 32'h0C);
        chk("right_pos",   32'(rf[17]), 32'h02);
        chk("right_depth", 32'(rf[18]), 32'h02);

        // Rejected moves: edge of board, depth limit, out-of-range position.
        preset(8'd0, 8'd0, 1'b1);  sync_rf(); model_cmd(2'b10, 5); issue(2'b10, 1'b0);
        preset(8'd4, 8'd16, 1'b1); sync_rf(); model_cmd(2'b00, 5); issue(2'b00, 1'b0);
        preset(8'd9, 8'd0, 1'b1);  sync_rf(); model_cmd(2'b01, 5); issue(2'b01, 1'b0);

        // Abort during WR_NEW: the two writes already issued stay.
        preset(8'd4, 8'd3, 1'b1); sync_rf();
        model_cmd(2'b00, 2);
        @(negedge clk);
        bus.start = 1'b1; bus.dir = 2'b00; acc = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_we",   32'(bus.rf_we), 0);
        chk("abort_q",    32'(expq.size()), 0);
        rst_n = 1'b1;
        model_cmd(2'b10, 5); issue(2'b10, 1'b0);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 5) == 0 || (mem_m[18] >= 8'd16 && $urandom_range(0, 1) == 1)) begin
                pb = 8'($urandom_range(0, 9));
                if ($urandom_range(0, 7) == 0) pb = {4'($urandom), 4'($urandom_range(9, 15))};
                else if ($urandom_range(0, 3) == 0) pb[7:4] = 4'($urandom);
                preset(pb, 8'($urandom_range(0, 17)), 1'b1);
                sync_rf();
            end
            rd = 2'($urandom);
            model_cmd(rd, 5);
            issue(rd, $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        chk("end_wr_queue",   32'(expq.size()), 0);
        chk("end_done_queue", 32'(doneq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, required finish");
        $fatal(1);
    end
endmodule
